// File: rtl/csr_reg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | csr_reg_pkg : shared constants and the per-CSR writable-bit mask       |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package csr_reg_pkg;

   localparam logic RstEnable = 1'b0;
   localparam logic [31:0] ZeroWord = 32'h0000_0000;
   typedef logic [31:0] CsrRegBus;

   localparam logic [11:0] c_addr_mstatus   = 12'h300;
   localparam logic [11:0] c_addr_misa      = 12'h301;
   localparam logic [11:0] c_addr_mie       = 12'h304;
   localparam logic [11:0] c_addr_mtvec     = 12'h305;
   localparam logic [11:0] c_addr_mscratch  = 12'h340;
   localparam logic [11:0] c_addr_mepc      = 12'h341;
   localparam logic [11:0] c_addr_mcause    = 12'h342;
   localparam logic [11:0] c_addr_mtval     = 12'h343;
   localparam logic [11:0] c_addr_mip       = 12'h344;
   localparam logic [11:0] c_addr_mcycle    = 12'hB00;
   localparam logic [11:0] c_addr_minstret  = 12'hB02;
   localparam logic [11:0] c_addr_mcycleh   = 12'hB80;
   localparam logic [11:0] c_addr_minstreth = 12'hB82;
   localparam logic [11:0] c_addr_mhartid   = 12'hF14;

   localparam int c_bit_mie  = 3;
   localparam int c_bit_mpie = 7;
   localparam int c_bit_msi  = 3;
   localparam int c_bit_mti  = 7;
   localparam int c_bit_mei  = 11;

   // MPP is hardwired to machine mode
   localparam CsrRegBus c_mstatus_hw = 32'h0000_1800;

   function automatic CsrRegBus csr_wmask(input logic [11:0] addr);
      CsrRegBus m;
      m = ZeroWord;
      case (addr)
         c_addr_mstatus:   m = 32'h0000_0088;
         c_addr_mie:       m = 32'h0000_0888;
         c_addr_mtvec:     m = 32'hFFFF_FFFD;
         c_addr_mepc:      m = 32'hFFFF_FFFC;
         c_addr_mscratch,
         c_addr_mcause,
         c_addr_mtval,
         c_addr_mcycle,
         c_addr_minstret,
         c_addr_mcycleh,
         c_addr_minstreth: m = 32'hFFFF_FFFF;
         default:          m = ZeroWord;
      endcase
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | csr_counter64 : 64-bit counter with increment and word write ports     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module csr_counter64
   import csr_reg_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        inc_i,
   input  logic        wr_lo_i,
   input  logic        wr_hi_i,
   input  CsrRegBus    wdata_i,
   output logic [63:0] count_o
);

   CsrRegBus r_lo;
   CsrRegBus r_hi;
   logic     w_carry;

   // a write to either word swallows this cycle's carry
   assign w_carry = inc_i && !wr_lo_i && !wr_hi_i && (r_lo == 32'hFFFF_FFFF);

   always_ff @(posedge clk or negedge rstn) begin
      if (rstn == RstEnable) begin
         r_lo <= ZeroWord;
         r_hi <= ZeroWord;
      end else begin
         if (wr_lo_i)
            r_lo <= wdata_i;
         else if (inc_i)
            r_lo <= r_lo + 32'd1;
         if (wr_hi_i)
            r_hi <= wdata_i;
         else if (w_carry)
            r_hi <= r_hi + 32'd1;
      end
   end

   assign count_o = {r_hi, r_lo};

endmodule
`default_nettype wire

// File: rtl/csr_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | csr_reg : machine-mode CSR file, trap-controller views and counters    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module csr_reg
   import csr_reg_pkg::*;
#(
   parameter CsrRegBus MTVEC_RST = 32'h0000_0000,
   parameter CsrRegBus HART_ID   = 32'd0,
   parameter CsrRegBus MISA_VAL  = 32'h4000_0100
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [11:0] csr_raddr_i,
   output CsrRegBus    csr_rdata_o,
   input  logic        csr_we_i,
   input  logic [11:0] csr_waddr_i,
   input  CsrRegBus    csr_wdata_i,
   input  logic        instret_i,
   input  logic        set_cause_i,
   input  logic        cause_type_i,
   input  logic [3:0]  trap_cause_i,
   input  logic        set_mepc_i,
   input  CsrRegBus    mepc_i,
   input  logic        set_mtval_i,
   input  CsrRegBus    mtval_i,
   input  logic        mstatus_mie_clear_i,
   input  logic        mstatus_mie_set_i,
   input  logic        irq_software_i,
   input  logic        irq_timer_i,
   input  logic        irq_external_i,
   output logic        mstatus_mie_o,
   output logic        mie_sw_o,
   output logic        mie_timer_o,
   output logic        mie_external_o,
   output logic        mip_sw_o,
   output logic        mip_timer_o,
   output logic        mip_external_o,
   output CsrRegBus    mtvec_o,
   output CsrRegBus    mepc_o
);

   logic        r_mstatus_mie, r_mstatus_mpie;
   logic        r_mie_sw, r_mie_timer, r_mie_ext;
   logic        r_mip_sw, r_mip_timer, r_mip_ext;
   CsrRegBus    r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
   logic [63:0] w_mcycle, w_minstret;
   CsrRegBus    w_mstatus, w_mie_csr, w_mip_csr, w_rdata_raw, w_mask;
   logic        w_unused_mepc_lsb;

   logic w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch, w_wr_mepc;
   logic w_wr_mcause, w_wr_mtval, w_wr_mcycle, w_wr_mcycleh;
   logic w_wr_minstret, w_wr_minstreth;

   assign w_wr_mstatus   = csr_we_i && (csr_waddr_i == c_addr_mstatus);
   assign w_wr_mie       = csr_we_i && (csr_waddr_i == c_addr_mie);
   assign w_wr_mtvec     = csr_we_i && (csr_waddr_i == c_addr_mtvec);
   assign w_wr_mscratch  = csr_we_i && (csr_waddr_i == c_addr_mscratch);
   assign w_wr_mepc      = csr_we_i && (csr_waddr_i == c_addr_mepc);
   assign w_wr_mcause    = csr_we_i && (csr_waddr_i == c_addr_mcause);
   assign w_wr_mtval     = csr_we_i && (csr_waddr_i == c_addr_mtval);
   assign w_wr_mcycle    = csr_we_i && (csr_waddr_i == c_addr_mcycle);
   assign w_wr_mcycleh   = csr_we_i && (csr_waddr_i == c_addr_mcycleh);
   assign w_wr_minstret  = csr_we_i && (csr_waddr_i == c_addr_minstret);
   assign w_wr_minstreth = csr_we_i && (csr_waddr_i == c_addr_minstreth);

   assign w_unused_mepc_lsb = ^mepc_i[1:0];

   // hardware strobes take precedence over a software write to the same CSR
   always_ff @(posedge clk or negedge rstn) begin
      if (rstn == RstEnable) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mie_sw       <= 1'b0;
         r_mie_timer    <= 1'b0;
         r_mie_ext      <= 1'b0;
         r_mip_sw       <= 1'b0;
         r_mip_timer    <= 1'b0;
         r_mip_ext      <= 1'b0;
         r_mtvec        <= MTVEC_RST;
         r_mscratch     <= ZeroWord;
         r_mepc         <= ZeroWord;
         r_mcause       <= ZeroWord;
         r_mtval        <= ZeroWord;
      end else begin
         if (mstatus_mie_clear_i) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
         end else if (mstatus_mie_set_i) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
         end else if (w_wr_mstatus) begin
            r_mstatus_mie  <= csr_wdata_i[c_bit_mie];
            r_mstatus_mpie <= csr_wdata_i[c_bit_mpie];
         end
         if (w_wr_mie) begin
            r_mie_sw    <= csr_wdata_i[c_bit_msi];
            r_mie_timer <= csr_wdata_i[c_bit_mti];
            r_mie_ext   <= csr_wdata_i[c_bit_mei];
         end
         r_mip_sw    <= irq_software_i;
         r_mip_timer <= irq_timer_i;
         r_mip_ext   <= irq_external_i;
         if (w_wr_mtvec)
            r_mtvec <= {csr_wdata_i[31:2], 1'b0, csr_wdata_i[0]};
         if (w_wr_mscratch)
            r_mscratch <= csr_wdata_i;
         if (set_mepc_i)
            r_mepc <= {mepc_i[31:2], 2'b00};
         else if (w_wr_mepc)
            r_mepc <= {csr_wdata_i[31:2], 2'b00};
         if (set_cause_i)
            r_mcause <= {cause_type_i, 27'b0, trap_cause_i};
         else if (w_wr_mcause)
            r_mcause <= csr_wdata_i;
         if (set_mtval_i)
            r_mtval <= mtval_i;
         else if (w_wr_mtval)
            r_mtval <= csr_wdata_i;
      end
   end

   csr_counter64 u_mcycle (
      .clk     (clk),
      .rstn    (rstn),
      .inc_i   (1'b1),
      .wr_lo_i (w_wr_mcycle),
      .wr_hi_i (w_wr_mcycleh),
      .wdata_i (csr_wdata_i),
      .count_o (w_mcycle)
   );

   csr_counter64 u_minstret (
      .clk     (clk),
      .rstn    (rstn),
      .inc_i   (instret_i),
      .wr_lo_i (w_wr_minstret),
      .wr_hi_i (w_wr_minstreth),
      .wdata_i (csr_wdata_i),
      .count_o (w_minstret)
   );

   always_comb begin
      w_mstatus              = c_mstatus_hw;
      w_mstatus[c_bit_mie]   = r_mstatus_mie;
      w_mstatus[c_bit_mpie]  = r_mstatus_mpie;
      w_mie_csr              = ZeroWord;
      w_mie_csr[c_bit_msi]   = r_mie_sw;
      w_mie_csr[c_bit_mti]   = r_mie_timer;
      w_mie_csr[c_bit_mei]   = r_mie_ext;
      w_mip_csr              = ZeroWord;
      w_mip_csr[c_bit_msi]   = r_mip_sw;
      w_mip_csr[c_bit_mti]   = r_mip_timer;
      w_mip_csr[c_bit_mei]   = r_mip_ext;
   end

   always_comb begin
      w_rdata_raw = ZeroWord;
      case (csr_raddr_i)
         c_addr_mstatus:   w_rdata_raw = w_mstatus;
         c_addr_misa:      w_rdata_raw = MISA_VAL;
         c_addr_mie:       w_rdata_raw = w_mie_csr;
         c_addr_mtvec:     w_rdata_raw = r_mtvec;
         c_addr_mscratch:  w_rdata_raw = r_mscratch;
         c_addr_mepc:      w_rdata_raw = r_mepc;
         c_addr_mcause:    w_rdata_raw = r_mcause;
         c_addr_mtval:     w_rdata_raw = r_mtval;
         c_addr_mip:       w_rdata_raw = w_mip_csr;
         c_addr_mcycle:    w_rdata_raw = w_mcycle[31:0];
         c_addr_minstret:  w_rdata_raw = w_minstret[31:0];
         c_addr_mcycleh:   w_rdata_raw = w_mcycle[63:32];
         c_addr_minstreth: w_rdata_raw = w_minstret[63:32];
         c_addr_mhartid:   w_rdata_raw = HART_ID;
         default:          w_rdata_raw = ZeroWord;
      endcase
      // bypass shows the post-write value: writable bits from wdata, the rest as stored
      w_mask = csr_wmask(csr_raddr_i);
      if (csr_we_i && (csr_waddr_i == csr_raddr_i))
         csr_rdata_o = (csr_wdata_i & w_mask) | (w_rdata_raw & ~w_mask);
      else
         csr_rdata_o = w_rdata_raw;
   end

   assign mstatus_mie_o  = r_mstatus_mie;
   assign mie_sw_o       = r_mie_sw;
   assign mie_timer_o    = r_mie_timer;
   assign mie_external_o = r_mie_ext;
   assign mip_sw_o       = r_mip_sw;
   assign mip_timer_o    = r_mip_timer;
   assign mip_external_o = r_mip_ext;
   assign mtvec_o        = r_mtvec;
   assign mepc_o         = r_mepc;

endmodule
`default_nettype wire

// File: tb/tb_csr_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_csr_reg : directed and randomized checks of csr_reg against a model |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_csr_reg;

   localparam logic [31:0] TB_MTVEC_RST = 32'h0000_4000;
   localparam logic [31:0] TB_HART_ID   = 32'd7;
   localparam logic [31:0] TB_MISA      = 32'h4000_0100;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [11:0] csr_raddr_i = '0;
   logic [31:0] csr_rdata_o;
   logic        csr_we_i = 1'b0;
   logic [11:0] csr_waddr_i = '0;
   logic [31:0] csr_wdata_i = '0;
   logic        instret_i = 1'b0;
   logic        set_cause_i = 1'b0;
   logic        cause_type_i = 1'b0;
   logic [3:0]  trap_cause_i = '0;
   logic        set_mepc_i = 1'b0;
   logic [31:0] mepc_i = '0;
   logic        set_mtval_i = 1'b0;
   logic [31:0] mtval_i = '0;
   logic        mstatus_mie_clear_i = 1'b0;
   logic        mstatus_mie_set_i = 1'b0;
   logic        irq_software_i = 1'b0;
   logic        irq_timer_i = 1'b0;
   logic        irq_external_i = 1'b0;
   logic        mstatus_mie_o;
   logic        mie_sw_o, mie_timer_o, mie_external_o;
   logic        mip_sw_o, mip_timer_o, mip_external_o;
   logic [31:0] mtvec_o, mepc_o;

   always #5 clk = ~clk;

   csr_reg #(
      .MTVEC_RST (TB_MTVEC_RST),
      .HART_ID   (TB_HART_ID),
      .MISA_VAL  (TB_MISA)
   ) dut (
      .clk                 (clk),
      .rstn                (rstn),
      .csr_raddr_i         (csr_raddr_i),
      .csr_rdata_o         (csr_rdata_o),
      .csr_we_i            (csr_we_i),
      .csr_waddr_i         (csr_waddr_i),
      .csr_wdata_i         (csr_wdata_i),
      .instret_i           (instret_i),
      .set_cause_i         (set_cause_i),
      .cause_type_i        (cause_type_i),
      .trap_cause_i        (trap_cause_i),
      .set_mepc_i          (set_mepc_i),
      .mepc_i              (mepc_i),
      .set_mtval_i         (set_mtval_i),
      .mtval_i             (mtval_i),
      .mstatus_mie_clear_i (mstatus_mie_clear_i),
      .mstatus_mie_set_i   (mstatus_mie_set_i),
      .irq_software_i      (irq_software_i),
      .irq_timer_i         (irq_timer_i),
      .irq_external_i      (irq_external_i),
      .mstatus_mie_o       (mstatus_mie_o),
      .mie_sw_o            (mie_sw_o),
      .mie_timer_o         (mie_timer_o),
      .mie_external_o      (mie_external_o),
      .mip_sw_o            (mip_sw_o),
      .mip_timer_o         (mip_timer_o),
      .mip_external_o      (mip_external_o),
      .mtvec_o             (mtvec_o),
      .mepc_o              (mepc_o)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // reference model state, kept as architectural values
   bit          m_mie_b, m_mpie;
   logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
   logic [63:0] m_cycle, m_instret;

   task automatic mdl_reset();
      m_mie_b = 0; m_mpie = 0;
      m_mie = 0; m_mtvec = TB_MTVEC_RST; m_mscratch = 0; m_mepc = 0;
      m_mcause = 0; m_mtval = 0; m_mip = 0; m_cycle = 0; m_instret = 0;
   endtask

   function automatic logic [31:0] mdl_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie_b ? 32'h8 : 32'h0);
         12'h301: return TB_MISA;
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h344: return m_mip;
         12'hB00: return m_cycle[31:0];
         12'hB02: return m_instret[31:0];
         12'hB80: return m_cycle[63:32];
         12'hB82: return m_instret[63:32];
         12'hF14: return TB_HART_ID;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] mdl_wmask(input logic [11:0] a);
      case (a)
         12'h300: return 32'h0000_0088;
         12'h304: return 32'h0000_0888;
         12'h305: return 32'hFFFF_FFFD;
         12'h341: return 32'hFFFF_FFFC;
         12'h340, 12'h342, 12'h343, 12'hB00, 12'hB02, 12'hB80, 12'hB82: return 32'hFFFF_FFFF;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit sw_wr(input logic [11:0] a);
      return csr_we_i && (csr_waddr_i == a);
   endfunction

   // check the combinational read, advance one clock edge, then check the controller views
   task automatic tick();
      logic [31:0] exp_rd, msk;
      bit          n_mie_b, n_mpie;
      logic [31:0] n_mie, n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval, n_mip;
      logic [63:0] n_cycle, n_instret;
      #1;
      msk = mdl_wmask(csr_raddr_i);
      exp_rd = mdl_read(csr_raddr_i);
      if (csr_we_i && csr_waddr_i == csr_raddr_i)
         exp_rd = (csr_wdata_i & msk) | (exp_rd & ~msk);
      chk_val("rdata", csr_rdata_o, exp_rd);

      n_mie_b = m_mie_b; n_mpie = m_mpie;
      if (mstatus_mie_clear_i) begin n_mpie = m_mie_b; n_mie_b = 0; end
      else if (mstatus_mie_set_i) begin n_mie_b = m_mpie; n_mpie = 1; end
      else if (sw_wr(12'h300)) begin n_mie_b = csr_wdata_i[3]; n_mpie = csr_wdata_i[7]; end
      n_mie      = sw_wr(12'h304) ? (csr_wdata_i & 32'h888) : m_mie;
      n_mtvec    = sw_wr(12'h305) ? (csr_wdata_i & ~32'h2) : m_mtvec;
      n_mscratch = sw_wr(12'h340) ? csr_wdata_i : m_mscratch;
      n_mepc     = set_mepc_i ? (mepc_i & ~32'h3) : sw_wr(12'h341) ? (csr_wdata_i & ~32'h3) : m_mepc;
      n_mcause   = set_cause_i ? ((cause_type_i ? 32'h8000_0000 : 32'h0) + 32'(trap_cause_i))
                 : sw_wr(12'h342) ? csr_wdata_i : m_mcause;
      n_mtval    = set_mtval_i ? mtval_i : sw_wr(12'h343) ? csr_wdata_i : m_mtval;
      n_mip      = (irq_software_i ? 32'h8 : 32'h0) + (irq_timer_i ? 32'h80 : 32'h0)
                 + (irq_external_i ? 32'h800 : 32'h0);
      if (sw_wr(12'hB00))      n_cycle = {m_cycle[63:32], csr_wdata_i};
      else if (sw_wr(12'hB80)) n_cycle = {csr_wdata_i, m_cycle[31:0] + 32'd1};
      else                     n_cycle = m_cycle + 64'd1;
      if (sw_wr(12'hB02))      n_instret = {m_instret[63:32], csr_wdata_i};
      else if (sw_wr(12'hB82)) n_instret = {csr_wdata_i, m_instret[31:0] + (instret_i ? 32'd1 : 32'd0)};
      else                     n_instret = m_instret + (instret_i ? 64'd1 : 64'd0);

      @(posedge clk);
      m_mie_b = n_mie_b; m_mpie = n_mpie; m_mie = n_mie; m_mtvec = n_mtvec;
      m_mscratch = n_mscratch; m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval;
      m_mip = n_mip; m_cycle = n_cycle; m_instret = n_instret;
      #1;
      chk_val("ctrl_bits",
              {mstatus_mie_o, mie_sw_o, mie_timer_o, mie_external_o, mip_sw_o, mip_timer_o, mip_external_o},
              {m_mie_b, m_mie[3], m_mie[7], m_mie[11], m_mip[3], m_mip[7], m_mip[11]});
      chk_val("mtvec_o", mtvec_o, m_mtvec);
      chk_val("mepc_o", mepc_o, m_mepc);
   endtask

   task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
      csr_raddr_i = a;
      #1;
      chk_val(tag, csr_rdata_o, exp);
   endtask

   task automatic sw_write(input logic [11:0] a, input logic [31:0] d);
      csr_we_i = 1; csr_waddr_i = a; csr_wdata_i = d;
      tick();
      csr_we_i = 0;
   endtask

   logic [11:0] addrs [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                               12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                               12'hB82, 12'hF14, 12'h345, 12'h7C0};

   initial begin
      mdl_reset();
      #2;
      // every CSR while held in reset
      for (int i = 0; i < 16; i++)
         peek("rst_read", addrs[i], mdl_read(addrs[i]));
      peek("rst_mstatus", 12'h300, 32'h0000_1800);
      peek("rst_mtvec", 12'h305, TB_MTVEC_RST);
      peek("rst_misa", 12'h301, TB_MISA);
      chk_val("rst_mtvec_o", mtvec_o, TB_MTVEC_RST);
      @(posedge clk); #1;
      rstn = 1;

      sw_write(12'h305, 32'h0000_0103);
      peek("mtvec_wr", 12'h305, 32'h0000_0101);

      csr_we_i = 1; csr_waddr_i = 12'h340; csr_wdata_i = 32'hDEAD_BEEF; csr_raddr_i = 12'h340;
      #1;
      chk_val("bypass_mscratch", csr_rdata_o, 32'hDEAD_BEEF);
      tick();
      csr_we_i = 0;

      sw_write(12'h300, 32'h0000_0008);
      mstatus_mie_clear_i = 1; set_cause_i = 1; cause_type_i = 1; trap_cause_i = 4'hB;
      set_mepc_i = 1; mepc_i = 32'h0000_0206;
      tick();
      mstatus_mie_clear_i = 0; set_cause_i = 0; set_mepc_i = 0;
      peek("trap_mstatus", 12'h300, 32'h0000_1880);
      peek("trap_mcause", 12'h342, 32'h8000_000B);
      peek("trap_mepc", 12'h341, 32'h0000_0204);
      mstatus_mie_set_i = 1;
      tick();
      mstatus_mie_set_i = 0;
      peek("mret_mstatus", 12'h300, 32'h0000_1888);

      set_mepc_i = 1; mepc_i = 32'h2222_2220;
      sw_write(12'h341, 32'h1111_1110);
      set_mepc_i = 0;
      peek("hw_over_sw_mepc", 12'h341, 32'h2222_2220);
      mstatus_mie_clear_i = 1; mstatus_mie_set_i = 1;
      tick();
      mstatus_mie_clear_i = 0; mstatus_mie_set_i = 0;
      peek("both_strobes", 12'h300, 32'h0000_1880);

      sw_write(12'hB00, 32'hFFFF_FFFE);
      peek("mcycle_wr", 12'hB00, 32'hFFFF_FFFE);
      tick();
      tick();
      peek("mcycle_wrap", 12'hB00, 32'h0);
      peek("mcycleh_carry", 12'hB80, 32'h1);
      peek("minstret_idle", 12'hB02, 32'h0);

      sw_write(12'h304, 32'h0000_0888);
      irq_timer_i = 1;
      #1;
      chk_val("mip_timer_lat0", mip_timer_o, 1'b0);
      tick();
      chk_val("mip_timer_lat1", mip_timer_o, 1'b1);
      peek("mip_read", 12'h344, 32'h0000_0080);
      sw_write(12'h344, 32'hFFFF_FFFF);
      peek("mip_wr_ignored", 12'h344, 32'h0000_0080);

      sw_write(12'h341, 32'h8000_0010);
      peek("mepc_pre_rst", 12'h341, 32'h8000_0010);
      rstn = 0;
      #1;
      chk_val("async_rst_mepc_o", mepc_o, 32'h0);
      peek("async_rst_mepc", 12'h341, 32'h0);
      mdl_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstn = 1;

      for (int n = 0; n < 400; n++) begin
         csr_raddr_i = addrs[$urandom_range(0, 15)];
         csr_we_i = ($urandom_range(0, 1) == 1);
         csr_waddr_i = ($urandom_range(0, 3) == 0) ? csr_raddr_i : addrs[$urandom_range(0, 15)];
         csr_wdata_i = $urandom;
         instret_i = ($urandom_range(0, 1) == 1);
         set_cause_i = ($urandom_range(0, 7) == 0);
         cause_type_i = ($urandom_range(0, 1) == 1);
         trap_cause_i = 4'($urandom);
         set_mepc_i = ($urandom_range(0, 7) == 0);
         mepc_i = $urandom;
         set_mtval_i = ($urandom_range(0, 7) == 0);
         mtval_i = $urandom;
         mstatus_mie_clear_i = ($urandom_range(0, 7) == 0);
         mstatus_mie_set_i = ($urandom_range(0, 7) == 0);
         irq_software_i = ($urandom_range(0, 1) == 1);
         irq_timer_i = ($urandom_range(0, 1) == 1);
         irq_external_i = ($urandom_range(0, 1) == 1);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/csr_reg.md
Name: csr_reg

Overview:
Machine-mode CSR register file sitting directly downstream of the pipeline/trap controller. It consumes the trap-entry, trap-return, mcause, mepc and mtval update strobes. It returns to the controller the mstatus.MIE, mie, mip, mtvec and mepc views it needs for trap decisions. It also serves the single CSR read/write port used by the execute stage for Zicsr instructions, and runs the mcycle and minstret counters.

Parameters:
MTVEC_RST, 32'h0000_0000, reset value of mtvec
HART_ID, 0, value returned by mhartid
MISA_VAL, 32'h4000_0100, read-only misa value (RV32I)

Ports:
clk  in  1  core clock
rstn  in  1  reset, asynchronous, active-low
csr_raddr_i  in  12  read address from ex
csr_rdata_o  out  32  read data to ex
csr_we_i  in  1  software write enable from ex
csr_waddr_i  in  12  write address
csr_wdata_i  in  32  write data (already RS/RC-merged by ex)
instret_i  in  1  one instruction retired this cycle
set_cause_i  in  1  load mcause
cause_type_i  in  1  mcause[31]: 1 = interrupt
trap_cause_i  in  4  mcause[3:0]
set_mepc_i  in  1  load mepc
mepc_i  in  32  trapping instruction address
set_mtval_i  in  1  load mtval
mtval_i  in  32  mtval value
mstatus_mie_clear_i  in  1  trap entry
mstatus_mie_set_i  in  1  mret
irq_software_i / irq_timer_i / irq_external_i  in  1 each  raw interrupt lines
mstatus_mie_o  out  1  mstatus.MIE
mie_sw_o / mie_timer_o / mie_external_o  out  1 each  mie bits 3/7/11
mip_sw_o / mip_timer_o / mip_external_o  out  1 each  mip bits 3/7/11
mtvec_o  out  32  mtvec
mepc_o  out  32  mepc

Behaviour:
- Implemented CSRs: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mhartid 0xF14.
- Reset (rstn low, async) values:
  - mstatus = 32'h0000_1800 (MIE=0, MPIE=0, MPP=2'b11 hardwired).
  - mie, mscratch, mepc, mcause, mtval, counters, mip = 0.
  - mtvec = MTVEC_RST.
  - All outputs follow these values. Reset mid-operation discards any in-flight write.
- Read port is combinational, zero latency. Unimplemented address reads 32'h0.
- Read-after-write bypass: if csr_we_i and csr_waddr_i == csr_raddr_i, csr_rdata_o returns csr_wdata_i, masked to that register's writable bits.
- Writes take effect at the next rising edge.
  - Writes to misa, mhartid, mip and unimplemented addresses are ignored.
  - mstatus writes affect only bits 3 and 7.
  - mie writes affect only bits 3, 7 and 11.
  - mepc[1:0] and mtvec[1] are forced to 0.
- mip: bits 3/7/11 are registered copies of irq_software_i / irq_timer_i / irq_external_i. Exactly 1-cycle latency from input to mip_*_o.
- Trap entry (mstatus_mie_clear_i): MPIE <= MIE, MIE <= 0.
- mret (mstatus_mie_set_i): MIE <= MPIE, MPIE <= 1.
- Both trap entry and mret asserted in the same cycle: trap entry wins.
- set_cause_i: mcause <= {cause_type_i, 27'b0, trap_cause_i}.
- set_mepc_i: mepc <= {mepc_i[31:2], 2'b00}.
- set_mtval_i: mtval <= mtval_i.
- Priority: a hardware strobe and a software write to the same CSR in the same cycle → the hardware strobe wins and the software write to that CSR is dropped. Writes to other CSRs still occur.
- mcycle: 64-bit, +1 every cycle, wraps 2^64 → 0.
- minstret: 64-bit, +1 when instret_i is high.
- Counter writes:
  - A software write to a low word loads the written value and suppresses that cycle's increment; the high word is unchanged.
  - A write to a high word loads it; the low word still increments normally, but any carry out of the low word that cycle is discarded.
- Carry: low word 32'hFFFF_FFFF + 1 → low 0, high +1 in the same edge.

Decomposition:
- Shared defines header: CSR address constants, mstatus bit positions (MIE=3, MPIE=7), mie/mip bit positions (3/7/11), RstEnable, ZeroWord, CsrRegBus.
- One sub-module is natural: csr_counter64. It holds a 64-bit counter with an increment enable and low-word / high-word write ports, and is instantiated twice (mcycle, minstret).

Test Plan:
- Reset → read every CSR: mstatus 32'h1800, mtvec MTVEC_RST, misa MISA_VAL, all others 0. Mid-test reset clears mepc 32'h8000_0010 to 0 immediately, without a clock edge.
- Write mtvec 32'h0000_0103 → reads 32'h0000_0101. Write-plus-read of mscratch 32'hDEAD_BEEF in the same cycle → rdata 32'hDEAD_BEEF via bypass.
- Set MIE, then pulse mstatus_mie_clear_i + set_cause_i (type 1, cause 4'hB) + set_mepc_i 32'h0000_0206 → mstatus 32'h1880, mcause 32'h8000_000B, mepc 32'h0000_0204. Then pulse mstatus_mie_set_i → mstatus 32'h1888.
- Same cycle: csr_we_i to mepc 32'h1111_1110 and set_mepc_i 32'h2222_2220 → mepc 32'h2222_2220. Both MIE strobes together → the trap-entry result.
- Write mcycle 32'hFFFF_FFFE → reads 32'hFFFF_FFFE one cycle later. Two cycles later mcycle 0, mcycleh 1. minstret is unchanged while instret_i is low.
- Set mie 32'h0000_0888, raise irq_timer_i → mip_timer_o high exactly one cycle later, and mip read = 32'h80. A write to mip is ignored.
